// File: rtl/timer_arbiter.sv
// timer_arbiter: one shared down-counter handed out to up to four requesters.
// Round-robin winner selection by default; define TIMER_ARB_FIXED_PRIO_EN to make
// the lowest set REQ index win every arbitration instead.
module timer_arbiter #(
  parameter int unsigned CW = 8
) (
  input  logic            CLOCK,
  input  logic            RESET_N,
  input  logic            TICK,
  input  logic [3:0]      REQ,
  input  logic [4*CW-1:0] DLY,
  output logic [3:0]      GNT,
  output logic [3:0]      DONE,
  output logic            BUSY,
  output logic [CW-1:0]   COUNT
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [3:0]    done_q, done_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    owner_q, owner_d;

  logic          win_valid;
  logic [1:0]    win_idx;
  logic [CW-1:0] win_dly;

`ifdef TIMER_ARB_FIXED_PRIO_EN
  // Winner: lowest set request index.
  always_comb begin
    win_valid = |REQ;
    win_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (REQ[i]) win_idx = 2'(i);
    end
  end
`else
  logic [1:0] cand;
  logic       found;

  // Winner: first set request searching upward from the slot after the last owner.
  always_comb begin
    win_valid = |REQ;
    win_idx   = 2'd0;
    cand      = 2'd0;
    found     = 1'b0;
    for (int off = 1; off <= 4; off++) begin
      cand = ptr_q + 2'(off);
      if (!found && REQ[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end
`endif

  // Delay field belonging to the current winner, sampled only when granting.
  always_comb begin
    win_dly = DLY[win_idx*CW +: CW];
  end

  // Next-state logic: arbitration in idle, countdown/abort in run, done pulse in fin.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = 4'b0000;
    count_d = count_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          owner_d = win_idx;
          gnt_d   = 4'b0001 << win_idx;
          count_d = win_dly;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!REQ[owner_q]) begin
          // Withdrawn request wins over a coincident tick; no done pulse.
          gnt_d   = 4'b0000;
          count_d = '0;
          ptr_d   = owner_q;
          state_d = StIdle;
        end else if (count_q == '0) begin
          // Also the path for a zero delay: completes without any tick.
          gnt_d   = 4'b0000;
          done_d  = 4'b0001 << owner_q;
          state_d = StFin;
        end else if (TICK) begin
          count_d = count_q - 1'b1;
        end
      end
      StFin: begin
        ptr_d   = owner_q;
        state_d = StIdle;
      end
      default: begin
        gnt_d   = 4'b0000;
        count_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset abandons any delay in flight without a done pulse.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StIdle;
      gnt_q   <= 4'b0000;
      done_q  <= 4'b0000;
      count_q <= '0;
      ptr_q   <= 2'd3;
      owner_q <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    GNT   = gnt_q;
    DONE  = done_q;
    COUNT = count_q;
    BUSY  = (state_q != StIdle);
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter. Inputs change on the falling edge,
// outputs are sampled on the falling edge after each rising edge.
module tb_timer_arbiter;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic [3:0]  req;
  logic [31:0] dly;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  count;

  int total = 0;
  int bad   = 0;

  timer_arbiter #(.CW(8)) dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .TICK    (tick),
    .REQ     (req),
    .DLY     (dly),
    .GNT     (gnt),
    .DONE    (done),
    .BUSY    (busy),
    .COUNT   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  initial begin
    int e;
    rst_n = 1'b0;
    tick  = 1'b0;
    req   = 4'b0001;
    dly   = 32'h0101_0103;

    // Reset state with a request already waiting.
    repeat (2) nclk();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_done", done, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", count, 8'd0);

    // Test 1: requester 0, delay 3.
    rst_n = 1'b1;
    nclk();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_count3", count, 8'd3);
    chk("t1_busy", busy, 1'b1);
    for (int k = 2; k >= 0; k--) begin
      tick = 1'b1;
      nclk();
      tick = 1'b0;
      chk("t1_count_step", count, k);
      chk("t1_no_done", done, 4'b0000);
      if (k > 0) begin
        repeat (3) nclk();
        chk("t1_count_hold", count, k);
      end
    end
    nclk();
    chk("t1_done", done, 4'b0001);
    chk("t1_fin_gnt", gnt, 4'b0000);
    chk("t1_fin_busy", busy, 1'b1);
    req = 4'b0000;
    nclk();
    chk("t1_done_clr", done, 4'b0000);
    chk("t1_idle_busy", busy, 1'b0);

    // Test 2: all four requesting, delay 1 each.
    rst_n = 1'b0;
    nclk();
    rst_n = 1'b1;
    dly   = 32'h0101_0101;
    req   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
`ifdef TIMER_ARB_FIXED_PRIO_EN
      e = 0;
`else
      e = i % 4;
`endif
      nclk();
      chk("t2_gnt", gnt, 4'b0001 << e);
      chk("t2_count1", count, 8'd1);
      tick = 1'b1;
      nclk();
      tick = 1'b0;
      chk("t2_count0", count, 8'd0);
      nclk();
      chk("t2_done", done, 4'b0001 << e);
      chk("t2_fin_gnt", gnt, 4'b0000);
      if (i == 4) req = 4'b0000;
      nclk();
      chk("t2_done_clr", done, 4'b0000);
      chk("t2_idle_busy", busy, 1'b0);
    end

    // Test 3: zero delay on requester 2 completes without a tick.
    dly = 32'h0700_0501;
    req = 4'b0100;
    nclk();
    chk("t3_gnt", gnt, 4'b0100);
    chk("t3_count", count, 8'd0);
    nclk();
    chk("t3_done", done, 4'b0100);
    chk("t3_fin_gnt", gnt, 4'b0000);
    req = 4'b0000;
    nclk();
    chk("t3_done_clr", done, 4'b0000);
    chk("t3_idle_busy", busy, 1'b0);

    // Test 4: requester 1 aborts after two ticks, requester 3 pending.
    req = 4'b0010;
    nclk();
    chk("t4_gnt1", gnt, 4'b0010);
    chk("t4_count5", count, 8'd5);
    req  = 4'b1010;
    tick = 1'b1;
    nclk();
    tick = 1'b0;
    chk("t4_count4", count, 8'd4);
    nclk();
    tick = 1'b1;
    nclk();
    tick = 1'b0;
    chk("t4_count3", count, 8'd3);
    chk("t4_gnt_kept", gnt, 4'b0010);
    // Abort together with a tick.
    req  = 4'b1000;
    tick = 1'b1;
    nclk();
    chk("t4_abort_gnt", gnt, 4'b0000);
    chk("t4_abort_count", count, 8'd0);
    chk("t4_abort_done", done, 4'b0000);
    chk("t4_abort_busy", busy, 1'b0);
    // Tick still high in idle while requester 3 is granted.
    nclk();
    tick = 1'b0;
    chk("t4_gnt3", gnt, 4'b1000);
    chk("t4_count7", count, 8'd7);
    nclk();
    chk("t4_count7_hold", count, 8'd7);
    chk("t4_no_done", done, 4'b0000);

    // Test 5: reset mid-run with count 4.
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      nclk();
      tick = 1'b0;
    end
    chk("t5_count4", count, 8'd4);
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    chk("t5_async_gnt", gnt, 4'b0000);
    chk("t5_async_count", count, 8'd0);
    chk("t5_async_busy", busy, 1'b0);
    chk("t5_async_done", done, 4'b0000);
    nclk();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nclk();
      chk("t5_post_done", done, 4'b0000);
      chk("t5_post_gnt", gnt, 4'b0000);
    end
    // With pointer back at 3, requester 1 beats requester 3.
    req = 4'b1010;
    nclk();
    chk("t5_ptr_gnt", gnt, 4'b0010);
    chk("t5_ptr_count", count, 8'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
